// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ARB_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    DONE
  } arb_state_t;

  function automatic logic [ARB_PORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick2.sv
// Two-way round-robin pick: on a tie the port not granted last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [ARB_PORTS-1:0] req,
  input  logic                 last,
  output logic [ARB_PORTS-1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates two requesters onto a single memory-controller CPU port,
// with stall handling and a hold timeout that completes the transaction with err.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_hold,
  output logic [1:0]  grant
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arb_state_t           r_state;
  logic [7:0]           r_cnt;
  logic                 r_owner;
  logic                 r_we;
  logic                 r_last;
  logic                 r_rd;
  logic                 r_wr;
  logic                 r_err;
  logic [ARB_PORTS-1:0] r_ack;
  logic [ARB_PORTS-1:0] r_grant;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;

  logic [ARB_PORTS-1:0] w_req;
  logic [ARB_PORTS-1:0] w_gnt;
  logic                 w_sel;
  logic                 w_we;
  logic [31:0]          w_addr;
  logic [31:0]          w_wdata;

  assign w_req = {m1_req, m0_req};

  rr_pick2 u_pick (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt)
  );

  assign w_sel   = w_gnt[1];
  assign w_we    = w_sel ? m1_we    : m0_we;
  assign w_addr  = w_sel ? m1_addr  : m0_addr;
  assign w_wdata = w_sel ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_last  <= 1'b1;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= '0;
      r_grant <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_ack <= '0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (|w_req) begin
            r_state <= ISSUE;
            r_owner <= w_sel;
            r_grant <= w_gnt;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_rd    <= ~w_we;
            r_wr    <= w_we;
          end
        end
        ISSUE: begin
          // Counter holds the number of stalled edges already seen, so the
          // strobe stays up for exactly TIMEOUT cycles before aborting.
          if (!mem_hold) begin
            r_state <= RESP;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_ack   <= port_onehot(r_owner);
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESP: begin
          r_state <= DONE;
          r_rdata <= r_we ? '0 : mem_rdata;
          r_err   <= 1'b0;
          r_ack   <= port_onehot(r_owner);
        end
        DONE: begin
          r_state <= IDLE;
          r_last  <= r_owner;
          r_grant <= '0;
          r_rdata <= '0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = r_rd;
  assign mem_wr    = r_wr;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign grant     = r_grant;

  assign m0_ack   = r_ack[0];
  assign m1_ack   = r_ack[1];
  assign m0_err   = r_ack[0] & r_err;
  assign m1_err   = r_ack[1] & r_err;
  assign m0_rdata = r_ack[0] ? r_rdata : '0;
  assign m1_rdata = r_ack[1] ? r_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: masters push expected completions, a monitor
// pops them on ack, a memory responder drives stalls and read data.
module tb_mem_arb;

  localparam int unsigned TO = 16;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned lat;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [31:0] addr_v [2];
  logic [31:0] wdata_v [2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_hold;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   gq[$];

  int unsigned hold_of  [logic [31:0]];
  logic        we_of    [logic [31:0]];
  logic [31:0] wdata_of [logic [31:0]];

  mem_arb #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (req_v[0]),
    .m0_we     (we_v[0]),
    .m0_addr   (addr_v[0]),
    .m0_wdata  (wdata_v[0]),
    .m0_rdata  (m0_rdata),
    .m0_ack    (m0_ack),
    .m0_err    (m0_err),
    .m1_req    (req_v[1]),
    .m1_we     (we_v[1]),
    .m1_addr   (addr_v[1]),
    .m1_wdata  (wdata_v[1]),
    .m1_rdata  (m1_rdata),
    .m1_ack    (m1_ack),
    .m1_err    (m1_err),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_hold  (mem_hold),
    .grant     (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rmodel(input logic [31:0] a);
    if (a == 32'h0000_2004) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] mk_addr(input int p, input int unsigned seq);
    logic [19:0] s;
    logic        pb;
    s  = seq[19:0];
    pb = p[0];
    return {9'd1, pb, s, 2'b00};
  endfunction

  function automatic logic ack_of(input int p);
    return (p == 0) ? m0_ack : m1_ack;
  endfunction

  task automatic set_req(input int p, input logic [31:0] a, input logic we,
                         input logic [31:0] d, input int unsigned h);
    hold_of[a]  = h;
    we_of[a]    = we;
    wdata_of[a] = d;
    addr_v[p]   = a;
    wdata_v[p]  = d;
    we_v[p]     = we;
  endtask

  task automatic do_tx(input int p, input logic [31:0] a, input logic we,
                       input logic [31:0] d, input int unsigned h, input bit drop);
    exp_t e;
    bit   done;
    bit   dropped;
    done    = 1'b0;
    dropped = 1'b0;
    @(posedge clk);
    #1;
    set_req(p, a, we, d, h);
    e.err   = (h >= TO);
    e.rdata = (e.err || we) ? 32'd0 : rmodel(a);
    e.lat   = e.err ? TO : h + 2;
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    req_v[p] = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ack_of(p)) begin
        done = 1'b1;
        break;
      end
      if (drop && !dropped && grant == ((p == 0) ? 2'b01 : 2'b10)) begin
        @(posedge clk);
        #1 req_v[p] = 1'b0;
        dropped = 1'b1;
      end
    end
    check("ack_arrived", 32'(done), 32'd1);
  endtask

  task automatic run_master(input int p, input int n, input bit contin, input int unsigned base);
    for (int k = 0; k < n; k++) begin
      logic        we;
      int unsigned h;
      int unsigned r;
      int unsigned gap;
      bit          drop;
      we = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 6)       h = $urandom_range(0, 3);
      else if (r == 6) h = TO - 1;
      else if (r == 7) h = TO;
      else if (r == 8) h = TO + 2;
      else             h = $urandom_range(4, 8);
      drop = ($urandom_range(0, 5) == 0);
      gap  = $urandom_range(0, 3);
      if (contin) begin
        h    = 0;
        drop = 1'b0;
        gap  = 0;
      end
      do_tx(p, mk_addr(p, base + k), we, $urandom, h, drop);
      if (gap > 0) begin
        @(posedge clk);
        #1 req_v[p] = 1'b0;
        repeat (gap - 1) @(posedge clk);
      end
    end
    @(posedge clk);
    #1 req_v[p] = 1'b0;
  endtask

  // Memory controller model: stalls each transaction for its chosen number of
  // edges, returns read data one cycle after acceptance, random otherwise.
  initial begin
    int unsigned cnt;
    int unsigned h;
    int unsigned exp_len;
    bit          in_tx;
    bit          acc;
    logic [31:0] cur;
    logic [31:0] acc_addr;
    cnt = 0; h = 0; in_tx = 0; acc = 0; cur = '0; acc_addr = '0;
    mem_hold  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt = 0; in_tx = 0; acc = 0;
        mem_hold  = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        continue;
      end
      mem_rdata = acc ? rmodel(acc_addr) : $urandom;
      acc = 0;
      if (mem_rd || mem_wr) begin
        if (!in_tx) begin
          in_tx = 1;
          cnt   = 0;
          cur   = mem_addr;
          check("strobe_addr_known", 32'(hold_of.exists(cur)), 32'd1);
          h = hold_of.exists(cur) ? hold_of[cur] : 0;
        end
        check("mem_addr_stable", mem_addr, cur);
        if (we_of.exists(cur)) begin
          check("mem_dir", 32'({mem_rd, mem_wr}), we_of[cur] ? 32'd1 : 32'd2);
          check("mem_wdata", mem_wdata, wdata_of[cur]);
        end
        mem_hold = (cnt < h);
        if (!mem_hold) begin
          acc      = 1;
          acc_addr = cur;
        end
        cnt++;
      end else begin
        if (in_tx) begin
          exp_len = (h < TO) ? h + 1 : TO;
          check("strobe_len", cnt, exp_len);
          in_tx = 0;
        end
        mem_hold = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: per-cycle properties, round-robin grant model, scoreboard pops.
  initial begin
    int unsigned cyc;
    int unsigned gcyc;
    logic [1:0]  pg;
    logic [1:0]  pr;
    logic [1:0]  pa;
    logic [1:0]  ack;
    logic [1:0]  exp_g;
    logic        last;
    exp_t        e;
    cyc = 0; gcyc = 0; pg = '0; pr = '0; pa = '0; last = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      ack = {m1_ack, m0_ack};
      if (!rst) begin
        check("rst_quiet_ctl", 32'({mem_rd, mem_wr, grant, ack, m1_err, m0_err}), 32'd0);
        check("rst_quiet_rdata", m0_rdata | m1_rdata, 32'd0);
        last = 1'b1;
        pg   = '0;
        pr   = req_v;
        pa   = '0;
        continue;
      end
      check("strobe_excl", 32'(mem_rd & mem_wr), 32'd0);
      check("strobe_owned", 32'((mem_rd | mem_wr) && grant == 2'b00), 32'd0);
      check("ack_onehot", 32'(ack == 2'b11), 32'd0);
      check("ack_width", 32'(ack & pa), 32'd0);
      if (!m0_ack) begin
        check("m0_idle_rdata", m0_rdata, 32'd0);
        check("m0_idle_err", 32'(m0_err), 32'd0);
      end
      if (!m1_ack) begin
        check("m1_idle_rdata", m1_rdata, 32'd0);
        check("m1_idle_err", 32'(m1_err), 32'd0);
      end
      if (pg == 2'b00) begin
        if (pr == 2'b11) exp_g = last ? 2'b01 : 2'b10;
        else             exp_g = pr;
        check("grant_pick", 32'(grant), 32'(exp_g));
        if (grant != 2'b00) begin
          gcyc = cyc;
          gq.push_back(grant[1] ? 1 : 0);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (ack[p]) begin
          check("ack_owner", 32'(grant), (p == 0) ? 32'd1 : 32'd2);
          if ((p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            check("ack_expected", 32'd0, 32'd1);
          end else begin
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(p == 0 ? "m0_rdata" : "m1_rdata", p == 0 ? m0_rdata : m1_rdata, e.rdata);
            check(p == 0 ? "m0_err" : "m1_err", 32'(p == 0 ? m0_err : m1_err), 32'(e.err));
            check("ack_latency", cyc - gcyc, e.lat);
          end
          last = p[0];
        end
      end
      pg = grant;
      pr = req_v;
      pa = ack;
    end
  end

  initial begin
    bit seen;
    rst     = 1'b0;
    req_v   = '0;
    we_v    = '0;
    addr_v  = '{32'd0, 32'd0};
    wdata_v = '{32'd0, 32'd0};
    repeat (3) @(posedge clk);
    #1;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_strobe", 32'({mem_rd, mem_wr}), 32'd0);
    check("reset_ack", 32'({m1_ack, m0_ack}), 32'd0);
    rst = 1'b1;

    // both ports requesting back-to-back from reset must alternate 0,1,0,1...
    fork
      run_master(0, 4, 1'b1, 0);
      run_master(1, 4, 1'b1, 100);
    join
    check("alt_count", gq.size(), 32'd8);
    for (int i = 0; i < 8 && i < gq.size(); i++) check("alt_order", gq[i], i % 2);

    // directed: plain read, stalled write, timeout, last non-timeout stall
    do_tx(0, 32'h0000_2004, 1'b0, 32'd0, 0, 1'b0);
    @(posedge clk); #1 req_v[0] = 1'b0;
    do_tx(1, 32'h0000_0100, 1'b1, 32'h1234_5678, 3, 1'b0);
    @(posedge clk); #1 req_v[1] = 1'b0;
    do_tx(0, mk_addr(0, 3000), 1'b0, 32'd0, TO + 4, 1'b0);
    do_tx(0, mk_addr(0, 3001), 1'b0, 32'd0, TO - 1, 1'b0);
    do_tx(1, mk_addr(1, 3002), 1'b1, 32'hCAFE_0001, TO, 1'b1);
    @(posedge clk); #1 req_v = '0;

    fork
      run_master(0, 30, 1'b0, 1000);
      run_master(1, 30, 1'b0, 2000);
    join
    repeat (4) @(posedge clk);

    // reset during a stalled read: strobes drop at once, no ack, then normal service
    seen = 1'b0;
    @(posedge clk);
    #1;
    set_req(0, mk_addr(0, 5000), 1'b0, 32'd0, TO + 8);
    req_v[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_rd) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_strobe_seen", 32'(seen), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_strobe", 32'({mem_rd, mem_wr}), 32'd0);
    check("rst_async_grant", 32'(grant), 32'd0);
    check("rst_async_ack", 32'({m1_ack, m0_ack}), 32'd0);
    req_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    do_tx(0, mk_addr(0, 5001), 1'b0, 32'd0, 1, 1'b0);
    @(posedge clk); #1 req_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    check("sb_drain", exp_q0.size() + exp_q1.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the ISSUE cycles with mem_hold high before a transaction aborts; legal range 2..255.
REQ-002 clk  in  1  single system clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 m0_req/m1_req  in  1  requester i transaction request; held high until mi_ack.
REQ-005 m0_we/m1_we  in  1  1 = write, 0 = read; stable while mi_req high.
REQ-006 m0_addr/m1_addr  in  32  byte address; stable while mi_req high.
REQ-007 m0_wdata/m1_wdata  in  32  write data; stable while mi_req high.
REQ-008 m0_rdata/m1_rdata  out  32  read data, valid only in mi_ack cycle.
REQ-009 m0_ack/m1_ack  out  1  one-cycle completion pulse.
REQ-010 m0_err/m1_err  out  1  timeout flag, qualified by mi_ack.
REQ-011 mem_rd/mem_wr  out  1  read/write strobe to memory controller CPU port.
REQ-012 mem_addr  out  32  latched address of granted requester.
REQ-013 mem_wdata  out  32  latched write data.
REQ-014 mem_rdata  in  32  controller read data, valid one cycle after strobe accepted.
REQ-015 mem_hold  in  1  controller stall; strobe accepted on an edge where it is low.
REQ-016 grant  out  2  one-hot owner of current transaction, 0 when IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RESP, DONE.
REQ-018 IDLE: on any mi_req, pick winner, latch addr/we/wdata/port, clear timeout counter, go ISSUE; otherwise stay.
REQ-019 Arbitration SHALL be two-way round-robin: on simultaneous requests the port not granted last wins; single requester always wins.
REQ-020 ISSUE: mem_rd = ~we, mem_wr = we, held until an edge with mem_hold = 0, then go RESP.
REQ-021 ISSUE with mem_hold = 1: counter +1 per cycle; when counter reaches TIMEOUT-1 with mem_hold still 1, go DONE with err set, strobes low next cycle.
REQ-022 mem_rd and mem_wr SHALL never be high simultaneously and SHALL be low outside ISSUE.
REQ-023 RESP: register mem_rdata (reads) or 0 (writes) into rdata register, go DONE.
REQ-024 DONE: assert mi_ack of owner for exactly one cycle with registered rdata/err, update last-granted, go IDLE.
REQ-025 Minimum latency: req sampled at edge N, strobe from N+1, ack at N+3 when mem_hold = 0.
REQ-026 Non-owner mi_ack, mi_err and mi_rdata SHALL be 0 every cycle.
REQ-027 Timeout completion SHALL drive rdata = 0, err = 1.
REQ-028 Requester dropping mi_req mid-transaction SHALL NOT abort it; ack still pulses.
REQ-029 mi_req still high in ack cycle SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-030 rst low SHALL immediately force IDLE, strobes 0, ack/err 0, rdata 0, grant 0, counter 0, last-granted = port 1 (port 0 wins first tie).
REQ-031 Reset mid-transaction SHALL discard it without ack; no strobe after rst release until a new request.

Structure
REQ-032 State enum type arb_state_t and constant ARB_PORTS = 2 SHALL live in shared package mem_arb_pkg.
REQ-033 Round-robin pick SHALL be sub-module rr_pick2 (inputs req[1:0], last; output one-hot gnt).
REQ-034 Outputs to requesters and memory controller SHALL be registered or driven from FSM state only; no combinational in-to-out path.

Verification
REQ-035 m0 read of 0x0000_2004, mem_hold = 0, mem_rdata = 0xDEADBEEF -> mem_rd one cycle, m0_ack at N+3 with m0_rdata = 0xDEADBEEF, m0_err = 0.
REQ-036 m0 and m1 requesting continuously from reset -> grants alternate 0,1,0,1; no port starved.
REQ-037 m1 write 0x1234_5678 to 0x0000_0100, mem_hold high 3 cycles -> mem_wr held 4 cycles, mem_wdata stable, m1_ack after hold drops.
REQ-038 mem_hold stuck high, TIMEOUT = 16 -> strobe low after 16 cycles, mi_ack with err = 1, rdata = 0.
REQ-039 rst low during ISSUE -> strobes low same cycle, no ack, first request after release is served normally.
REQ-040 Every cycle assertions: mem_rd & mem_wr never both 1; ack one-hot; ack width exactly 1.
